// File: rtl/pes_err_pkg.sv
// Shared widths, FSM state type and error helpers for the adder-tree error monitor.
package pes_err_pkg;

    localparam int unsigned OP_W  = 8;   // operand width
    localparam int unsigned SUM_W = 11;  // exact / approximate sum width (max 2040)
    localparam int unsigned ERR_W = 12;  // signed error width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Magnitude of a 12-bit two's-complement error; reachable range fits in 11 bits.
    function automatic logic [SUM_W-1:0] abs_err(input logic [ERR_W-1:0] err);
        return err[ERR_W-1] ? SUM_W'(~err + ERR_W'(1)) : SUM_W'(err);
    endfunction

endpackage

// File: rtl/pes_exact_sum.sv
// Combinational exact sum of the eight 8-bit operands feeding the approximate tree.
module pes_exact_sum
    import pes_err_pkg::*;
(
    input  logic [OP_W-1:0]  i_a0,
    input  logic [OP_W-1:0]  i_a1,
    input  logic [OP_W-1:0]  i_a2,
    input  logic [OP_W-1:0]  i_a3,
    input  logic [OP_W-1:0]  i_b0,
    input  logic [OP_W-1:0]  i_b1,
    input  logic [OP_W-1:0]  i_b2,
    input  logic [OP_W-1:0]  i_b3,
    output logic [SUM_W-1:0] o_sum
);

    // Zero-extend every operand so the full 2040 range is carried.
    always_comb begin
        o_sum = SUM_W'(i_a0) + SUM_W'(i_a1) + SUM_W'(i_a2) + SUM_W'(i_a3)
              + SUM_W'(i_b0) + SUM_W'(i_b1) + SUM_W'(i_b2) + SUM_W'(i_b3);
    end

endmodule

// File: rtl/pes_err_mon.sv
// Error monitor: accepts operand/approximate-sum samples, recomputes the exact sum
// and accumulates error statistics over a programmed run of samples.
module pes_err_mon
    import pes_err_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned ACC_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    input  logic [CNT_W-1:0]  n_samples,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a0,
    input  logic [OP_W-1:0]   a1,
    input  logic [OP_W-1:0]   a2,
    input  logic [OP_W-1:0]   a3,
    input  logic [OP_W-1:0]   b0,
    input  logic [OP_W-1:0]   b1,
    input  logic [OP_W-1:0]   b2,
    input  logic [OP_W-1:0]   b3,
    input  logic [SUM_W-1:0]  y_apx,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic [CNT_W-1:0]  exact_cnt,
    output logic [ACC_W-1:0]  err_sum,
    output logic [SUM_W-1:0]  err_max,
    output logic [ERR_W-1:0]  err_last,
    output logic              ovf
);

    // Wide enough for accumulator plus one error without losing the carry.
    localparam int unsigned SAT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
    localparam logic [SAT_W-1:0] ACC_MAX = (SAT_W'(1) << ACC_W) - SAT_W'(1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  r_n_lat;
    logic [CNT_W-1:0]  r_acc_cnt;
    logic              w_start_ok;
    logic              w_flush;
    logic              w_xfer;

    logic [SUM_W-1:0]  w_exact;
    logic              r_v1;
    logic [SUM_W-1:0]  r_exact1;
    logic [SUM_W-1:0]  r_y1;
    logic              r_v2;
    logic [ERR_W-1:0]  r_err2;
    logic [ERR_W-1:0]  w_err1;

    logic [CNT_W-1:0]  r_sample_cnt;
    logic [CNT_W-1:0]  r_exact_cnt;
    logic [ACC_W-1:0]  r_err_sum;
    logic [SUM_W-1:0]  r_err_max;
    logic [ERR_W-1:0]  r_err_last;
    logic              r_ovf;

    logic [SUM_W-1:0]  w_abs2;
    logic [SAT_W-1:0]  w_sum_wide;
    logic              w_sat;
    logic [ACC_W-1:0]  w_sum_nxt;

    pes_exact_sum u_exact_sum (
        .i_a0  (a0),
        .i_a1  (a1),
        .i_a2  (a2),
        .i_a3  (a3),
        .i_b0  (b0),
        .i_b1  (b1),
        .i_b2  (b2),
        .i_b3  (b3),
        .o_sum (w_exact)
    );

    // Handshake and control qualifiers; clear overrides start.
    always_comb begin
        in_ready   = (r_state == RUN) && (r_acc_cnt < r_n_lat);
        w_xfer     = in_valid && in_ready;
        w_start_ok = start && !clear && ((r_state == IDLE) || (r_state == DONE));
        w_flush    = clear || w_start_ok;
        busy       = (r_state == RUN);
        done       = (r_state == DONE);
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = (n_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_acc_cnt == r_n_lat) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!r_v1 && !r_v2) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (clear) begin
            w_state_nxt = IDLE;
        end
    end

    // State register, latched run length and accepted-sample counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_n_lat   <= '0;
            r_acc_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_n_lat <= n_samples;
            end
            if (w_flush) begin
                r_acc_cnt <= '0;
            end else if (w_xfer) begin
                r_acc_cnt <= r_acc_cnt + CNT_W'(1);
            end
        end
    end

    // Error of the sample held in stage 1.
    always_comb begin
        w_err1 = {1'b0, r_y1} - {1'b0, r_exact1};
    end

    // Two-stage pipeline; clear/start drop any in-flight samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_exact1 <= '0;
            r_y1     <= '0;
            r_v2     <= 1'b0;
            r_err2   <= '0;
        end else begin
            r_v1 <= w_xfer && !w_flush;
            r_v2 <= r_v1 && !w_flush;
            if (w_xfer) begin
                r_exact1 <= w_exact;
                r_y1     <= y_apx;
            end
            if (r_v1) begin
                r_err2 <= w_err1;
            end
        end
    end

    // Saturating accumulation of the stage-2 error magnitude.
    always_comb begin
        w_abs2     = abs_err(r_err2);
        w_sum_wide = SAT_W'(r_err_sum) + SAT_W'(w_abs2);
        w_sat      = (w_sum_wide > ACC_MAX);
        w_sum_nxt  = w_sat ? {ACC_W{1'b1}} : w_sum_wide[ACC_W-1:0];
    end

    // Statistics registers, updated once per sample leaving stage 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample_cnt <= '0;
            r_exact_cnt  <= '0;
            r_err_sum    <= '0;
            r_err_max    <= '0;
            r_err_last   <= '0;
            r_ovf        <= 1'b0;
        end else if (w_flush) begin
            r_sample_cnt <= '0;
            r_exact_cnt  <= '0;
            r_err_sum    <= '0;
            r_err_max    <= '0;
            r_err_last   <= '0;
            r_ovf        <= 1'b0;
        end else if (r_v2) begin
            r_sample_cnt <= r_sample_cnt + CNT_W'(1);
            if (r_err2 == '0) begin
                r_exact_cnt <= r_exact_cnt + CNT_W'(1);
            end
            r_err_sum <= w_sum_nxt;
            if (w_abs2 > r_err_max) begin
                r_err_max <= w_abs2;
            end
            r_err_last <= r_err2;
            r_ovf      <= r_ovf || w_sat;
        end
    end

    // Output mapping.
    always_comb begin
        sample_cnt = r_sample_cnt;
        exact_cnt  = r_exact_cnt;
        err_sum    = r_err_sum;
        err_max    = r_err_max;
        err_last   = r_err_last;
        ovf        = r_ovf;
    end

endmodule

// File: doc/pes_err_mon.md
Name: pes_err_mon

Overview:
Sequential error monitor at the consumer end of the approximate 8-operand adder tree. Accepts one sample per cycle over a valid/ready handshake. Each sample is the eight 8-bit operands plus the approximate 11-bit tree sum. The block recomputes the exact sum, forms the signed error, and accumulates error statistics over a programmed run of N samples for characterisation in silicon and simulation.

Parameters:
CNT_W, 16, width of n_samples and the sample counters
ACC_W, 32, width of the absolute-error accumulator (saturating)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins a run (accepted only in IDLE or DONE)
clear  in  1  one-cycle pulse; zeroes stats, returns to IDLE
n_samples  in  CNT_W  run length, sampled on accepted start
in_valid  in  1  sample present
in_ready  out  1  block accepts the sample this cycle
a0,a1,a2,a3,b0,b1,b2,b3  in  8 each  operands
y_apx  in  11  approximate tree sum for these operands
busy  out  1  state is RUN
done  out  1  level; run complete, stats stable
sample_cnt  out  CNT_W  samples accumulated
exact_cnt  out  CNT_W  samples with zero error
err_sum  out  ACC_W  sum of |error|, saturating
err_max  out  11  maximum |error|
err_last  out  12  signed error of the latest accumulated sample
ovf  out  1  sticky; err_sum saturated

Behaviour:
- Reset: all outputs 0, state IDLE, pipeline valids 0. Reset mid-run discards in-flight samples.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start: latch n_samples, zero all stats and ovf, go to RUN. If n_samples==0, go directly to DONE.
  - RUN: when the accepted count reaches n_samples, go to DRAIN.
  - DRAIN: when both pipeline stages are empty, go to DONE.
  - Any state + clear: zero stats, go to IDLE. Clear beats start in the same cycle.
- in_ready = (state==RUN) and (accepted < n_latched). A transfer occurs when in_valid & in_ready. Inputs are ignored otherwise.
- Pipeline, 2 stages:
  - S1: register exact = zero-extended sum of the eight operands (11 bits, max 2040) and y_apx.
  - S2: err = y_apx - exact as 12-bit two's complement. abs = |err| (11 bits). Update stats.
- Latency: sample accepted at edge t is visible in outputs after edge t+2.
- Stats update in S2:
  - sample_cnt += 1.
  - exact_cnt += 1 if err==0.
  - err_sum += abs; saturates at all-ones and sets ovf.
  - err_max = max(err_max, abs).
  - err_last = err.
- Counters do not wrap. n_samples caps them at its maximum value.
- done = (state==DONE). busy = (state==RUN). Stats hold in DONE until start or clear.
- Back-to-back start in DONE is permitted and restarts immediately.

Decomposition:
- Package pes_err_pkg:
  - SUM_W=11, ERR_W=12
  - state enum {IDLE, RUN, DRAIN, DONE}
  - function abs_err
- Sub-module pes_exact_sum: combinational exact 8-operand adder producing an 11-bit sum. Instantiated once in S1.

Test Plan:
- start with n_samples=1; all operands 0, y_apx=1 -> after DONE: sample_cnt=1, err_last=+1, err_sum=1, err_max=1, exact_cnt=0, done=1.
- n_samples=2; sample 1: all operands 255, y_apx=2040; sample 2: same operands, y_apx=2000 -> exact_cnt=1, err_last=-40 (0xFD8), err_sum=40, err_max=40.
- ACC_W=8, n_samples=10; each sample has |error|=40 -> err_sum=255, ovf=1, sample_cnt=10, err_max=40.
- n_samples=0 with start -> DONE the next cycle, all stats 0, in_ready never asserted.
- start and clear in the same cycle while in DONE -> state IDLE, stats 0, busy=0.
- rst asserted with 3 samples in flight during RUN (n=8) -> outputs 0 immediately; after release the state is IDLE and no stale updates occur.
